// File: rtl/change_dispenser.sv
// Greedy coin payout engine: loads one change amount, issues 50/10/5/1
// coins one per handshake, then pulses done for a single cycle.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   change, change_valid, change_ready  amount input handshake
//   coin_out, coin_valid, coin_ready    one-hot coin output handshake
//   coin_count                        coins accepted this/last transaction
//   busy, done                        activity flag, end-of-transaction pulse
module change_dispenser #(
  parameter int W      = 6,
  parameter int COIN_A = 50,
  parameter int COIN_B = 10,
  parameter int COIN_C = 5,
  parameter int COIN_D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] change,
  input  logic         change_valid,
  output logic         change_ready,
  output logic [3:0]   coin_out,
  output logic         coin_valid,
  input  logic         coin_ready,
  output logic [3:0]   coin_count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE
  } state_t;

  state_t       state, state_d;
  logic [W-1:0] remaining, rem_d, rem_n;
  logic [3:0]   coin_d, cnt_d;

  // Largest coin not exceeding r; zero when nothing is left.
  function automatic logic [3:0] pick(
    input logic [W-1:0] r
  );
    logic [3:0] c;
    if (32'(r) >= COIN_A)      c = 4'b1000;
    else if (32'(r) >= COIN_B) c = 4'b0100;
    else if (32'(r) >= COIN_C) c = 4'b0010;
    else if (32'(r) >= COIN_D) c = 4'b0001;
    else                       c = 4'b0000;
    return c;
  endfunction

  function automatic logic [W-1:0] coin_val(
    input logic [3:0] c
  );
    logic [W-1:0] v;
    v = '0;
    unique case (1'b1)
      c[3]:    v = W'(COIN_A);
      c[2]:    v = W'(COIN_B);
      c[1]:    v = W'(COIN_C);
      c[0]:    v = W'(COIN_D);
      default: v = '0;
    endcase
    return v;
  endfunction

  assign change_ready = (state == IDLE);
  assign coin_valid   = (state == DISPENSE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_comb begin
    state_d = state;
    rem_d   = remaining;
    coin_d  = coin_out;
    cnt_d   = coin_count;
    rem_n   = remaining - coin_val(coin_out);
    unique case (state)
      IDLE: begin
        if (change_valid) begin
          cnt_d = '0;
          if (change != '0) begin
            rem_d   = change;
            coin_d  = pick(change);
            state_d = DISPENSE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DISPENSE: begin
        if (coin_ready) begin
          // Next offer is precomputed so coin_out is registered.
          rem_d  = rem_n;
          cnt_d  = coin_count + 4'd1;
          coin_d = pick(rem_n);
          if (rem_n == '0) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        coin_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      coin_out   <= '0;
      coin_count <= '0;
    end else begin
      state      <= state_d;
      remaining  <= rem_d;
      coin_out   <= coin_d;
      coin_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed-vector bench for change_dispenser.
// Expected coin sequences are hand-computed greedy breakdowns.
module tb_change_dispenser;

  localparam logic [3:0] CA = 4'b1000;
  localparam logic [3:0] CB = 4'b0100;
  localparam logic [3:0] CC = 4'b0010;
  localparam logic [3:0] CD = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] change = '0;
  logic       change_valid = 1'b0;
  logic       change_ready;
  logic [3:0] coin_out;
  logic       coin_valid;
  logic       coin_ready = 1'b1;
  logic [3:0] coin_count;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;

  change_dispenser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .change       (change),
    .change_valid (change_valid),
    .change_ready (change_ready),
    .coin_out     (coin_out),
    .coin_valid   (coin_valid),
    .coin_ready   (coin_ready),
    .coin_count   (coin_count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Load amt at the next edge, then check n coins (nibble i of seq
  // is coin i) with coin_ready high, the done cycle and return to IDLE.
  task automatic run(
    input string       tag,
    input logic [5:0]  amt,
    input logic [63:0] seq,
    input int          n
  );
    chk({tag, " rdy0"}, 32'(change_ready), 1);
    change       = amt;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s vld%0d", tag, i), 32'(coin_valid), 1);
      chk($sformatf("%s coin%0d", tag, i), 32'(coin_out), 32'(seq[4*i +: 4]));
      chk($sformatf("%s cnt%0d", tag, i), 32'(coin_count), i);
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " dvld"}, 32'(coin_valid), 0);
    chk({tag, " dout"}, 32'(coin_out), 0);
    chk({tag, " cnt"}, 32'(coin_count), n);
    @(negedge clk);
    chk({tag, " rdy"}, 32'(change_ready), 1);
    chk({tag, " done0"}, 32'(done), 0);
    chk({tag, " hold"}, 32'(coin_count), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst rdy", 32'(change_ready), 1);
    chk("rst vld", 32'(coin_valid), 0);
    chk("rst out", 32'(coin_out), 0);
    chk("rst cnt", 32'(coin_count), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("c38", 6'd38, 64'h1112444, 7);
    run("c63", 6'd63, 64'h11148, 5);
    run("c49", 6'd49, 64'h111124444, 9);
    run("c0", 6'd0, 64'h0, 0);

    // Stall during the second offer of 16.
    change       = 6'd16;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    chk("s16 c0", 32'(coin_out), 32'(CB));
    @(negedge clk);
    chk("s16 c1", 32'(coin_out), 32'(CC));
    coin_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("s16 hold%0d", i), 32'(coin_out), 32'(CC));
      chk($sformatf("s16 hv%0d", i), 32'(coin_valid), 1);
      chk($sformatf("s16 hc%0d", i), 32'(coin_count), 1);
    end
    coin_ready = 1'b1;
    @(negedge clk);
    chk("s16 c2", 32'(coin_out), 32'(CD));
    chk("s16 cnt2", 32'(coin_count), 2);
    @(negedge clk);
    chk("s16 done", 32'(done), 1);
    chk("s16 cnt", 32'(coin_count), 3);
    @(negedge clk);

    // Amount 25 offered while paying 10: held off until IDLE.
    change       = 6'd10;
    change_valid = 1'b1;
    @(negedge clk);
    chk("i10 c0", 32'(coin_out), 32'(CB));
    change = 6'd25;
    @(negedge clk);
    chk("i10 done", 32'(done), 1);
    chk("i10 rdy", 32'(change_ready), 0);
    chk("i10 cnt", 32'(coin_count), 1);
    @(negedge clk);
    chk("i10 idle", 32'(change_ready), 1);
    chk("i10 nvld", 32'(coin_valid), 0);
    chk("i10 hold", 32'(coin_count), 1);
    @(negedge clk);
    change_valid = 1'b0;
    chk("i25 c0", 32'(coin_out), 32'(CB));
    chk("i25 cnt0", 32'(coin_count), 0);
    @(negedge clk);
    chk("i25 c1", 32'(coin_out), 32'(CB));
    @(negedge clk);
    chk("i25 c2", 32'(coin_out), 32'(CC));
    @(negedge clk);
    chk("i25 done", 32'(done), 1);
    chk("i25 cnt", 32'(coin_count), 3);
    @(negedge clk);

    // Reset during the second coin of 38.
    change       = 6'd38;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    @(negedge clk);
    chk("r38 c1", 32'(coin_out), 32'(CB));
    #2 rst_n = 1'b0;
    #1;
    chk("r38 vld", 32'(coin_valid), 0);
    chk("r38 out", 32'(coin_out), 0);
    chk("r38 cnt", 32'(coin_count), 0);
    chk("r38 busy", 32'(busy), 0);
    chk("r38 rdy", 32'(change_ready), 1);
    chk("r38 done", 32'(done), 0);
    @(negedge clk);
    chk("r38 nd", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r38 nd2", 32'(done), 0);
    run("c5", 6'd5, 64'h2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
